// File: rtl/axi4_rd_burst_to_lite.sv
// axi4_rd_burst_to_lite: splits AXI4 read bursts into single-beat AXI4-Lite reads and rebuilds the R stream.
// Optional AXI_RD_ERR_ABORT_EN: after an error response the rest of the burst skips the Lite slave.
module axi4_rd_burst_to_lite #(
   parameter int C_ADDR_WIDTH = 32,
   parameter int C_DATA_WIDTH = 32,
   parameter int C_ID_WIDTH   = 1
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [C_ID_WIDTH-1:0]   S_AXI_ARID,
   input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [7:0]              S_AXI_ARLEN,
   input  logic [2:0]              S_AXI_ARSIZE,
   input  logic [1:0]              S_AXI_ARBURST,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [C_ID_WIDTH-1:0]   S_AXI_RID,
   output logic [C_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RLAST,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic [C_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                    M_AXI_ARVALID,
   input  logic                    M_AXI_ARREADY,
   input  logic [C_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]              M_AXI_RRESP,
   input  logic                    M_AXI_RVALID,
   output logic                    M_AXI_RREADY
);
   typedef enum logic [1:0] {IDLE, ADDR, WAIT_R, SEND_R} state_t;
   localparam logic [2:0] MAX_SIZE = 3'($clog2(C_DATA_WIDTH / 8));
   localparam logic [C_ADDR_WIDTH-1:0] ONE = {{(C_ADDR_WIDTH-1){1'b0}}, 1'b1};
   state_t                  state_q, state_d;
   logic [C_ID_WIDTH-1:0]   id_q, id_d, rid_q, rid_d;
   logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]              len_q, len_d, beat_q, beat_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d, rresp_q, rresp_d;
   logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                    skip_q, skip_d, arready_q, arready_d, m_arvalid_q, m_arvalid_d;
   logic                    m_rready_q, m_rready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [C_ADDR_WIDTH-1:0] inc, mask, next_addr;
   logic                    illegal, lite_err;

   always_comb begin
      inc       = ONE << size_q;
      mask      = ((C_ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;
      next_addr = burst_q == 2'b00 ? addr_q :
                  burst_q == 2'b10 ? (addr_q & ~mask) | ((addr_q + inc) & mask) : addr_q + inc;
      illegal   = (S_AXI_ARBURST == 2'b11) ||
                  (S_AXI_ARBURST == 2'b10 && !(S_AXI_ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                  (S_AXI_ARSIZE > MAX_SIZE);
`ifdef AXI_RD_ERR_ABORT_EN
      lite_err  = M_AXI_RRESP[1];
`else
      lite_err  = 1'b0;
`endif
      state_d     = state_q;
      id_d        = id_q;
      rid_d       = rid_q;
      addr_d      = addr_q;
      len_d       = len_q;
      beat_d      = beat_q;
      size_d      = size_q;
      burst_d     = burst_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
      skip_d      = skip_q;
      arready_d   = arready_q;
      m_arvalid_d = m_arvalid_q;
      m_rready_d  = m_rready_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (S_AXI_ARVALID && arready_q) begin
               arready_d = 1'b0;
               id_d      = S_AXI_ARID;
               addr_d    = S_AXI_ARADDR;
               len_d     = S_AXI_ARLEN;
               size_d    = S_AXI_ARSIZE;
               burst_d   = S_AXI_ARBURST;
               beat_d    = 8'd0;
               skip_d    = illegal;
               // Illegal bursts answer every beat locally with SLVERR
               if (illegal) begin
                  state_d  = SEND_R;
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  rresp_d  = 2'b10;
                  rid_d    = S_AXI_ARID;
                  rlast_d  = S_AXI_ARLEN == 8'd0;
               end else begin
                  state_d     = ADDR;
                  m_arvalid_d = 1'b1;
               end
            end
         end
         ADDR: begin
            if (M_AXI_ARREADY && m_arvalid_q) begin
               m_arvalid_d = 1'b0;
               m_rready_d  = 1'b1;
               state_d     = WAIT_R;
            end
         end
         WAIT_R: begin
            if (M_AXI_RVALID && m_rready_q) begin
               m_rready_d = 1'b0;
               rvalid_d   = 1'b1;
               rdata_d    = M_AXI_RDATA;
               rresp_d    = M_AXI_RRESP;
               rid_d      = id_q;
               rlast_d    = beat_q == len_q;
               skip_d     = lite_err;
               state_d    = SEND_R;
            end
         end
         SEND_R: begin
            if (S_AXI_RREADY && rvalid_q) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  arready_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  beat_d = beat_q + 8'd1;
                  addr_d = next_addr;
                  // Skipped beats stay in SEND_R, keeping the previous RRESP
                  if (skip_q) begin
                     rdata_d = '0;
                     rlast_d = (beat_q + 8'd1) == len_q;
                  end else begin
                     rvalid_d    = 1'b0;
                     m_arvalid_d = 1'b1;
                     state_d     = ADDR;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q     <= IDLE;
         id_q        <= '0;
         rid_q       <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         rresp_q     <= '0;
         rdata_q     <= '0;
         skip_q      <= 1'b0;
         arready_q   <= 1'b0;
         m_arvalid_q <= 1'b0;
         m_rready_q  <= 1'b0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         rid_q       <= rid_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         skip_q      <= skip_d;
         arready_q   <= arready_d;
         m_arvalid_q <= m_arvalid_d;
         m_rready_q  <= m_rready_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
      end
   end

   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RID     = rid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RLAST   = rlast_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARVALID = m_arvalid_q;
   assign M_AXI_RREADY  = m_rready_q;
endmodule

// File: doc/axi4_rd_burst_to_lite.md
Name: axi4_rd_burst_to_lite

Overview:
Read-path protocol converter placed directly downstream of the AXI4 interconnect connector's master read channels (AR/R). It accepts full AXI4 read bursts and issues them as a sequence of single-beat AXI4-Lite reads to a Lite register peripheral. It reassembles the Lite responses into a compliant AXI4 R stream with ID echo and RLAST. The write path is handled by a separate companion block.

Parameters:
C_ADDR_WIDTH, 32, address width on both sides.
C_DATA_WIDTH, 32, data width on both sides (32 or 64).
C_ID_WIDTH, 1, AXI4 ID width.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_ARID  in  C_ID_WIDTH  burst ID.
S_AXI_ARADDR  in  C_ADDR_WIDTH  start address.
S_AXI_ARLEN  in  8  beats minus 1.
S_AXI_ARSIZE  in  3  log2 of bytes per beat.
S_AXI_ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
S_AXI_ARVALID  in  1  AR valid.
S_AXI_ARREADY  out  1  AR ready.
S_AXI_RID  out  C_ID_WIDTH  echoed ID.
S_AXI_RDATA  out  C_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  beat response.
S_AXI_RLAST  out  1  final beat.
S_AXI_RVALID  out  1  R valid.
S_AXI_RREADY  in  1  R ready.
M_AXI_ARADDR  out  C_ADDR_WIDTH  Lite beat address.
M_AXI_ARVALID  out  1  Lite AR valid.
M_AXI_ARREADY  in  1  Lite AR ready.
M_AXI_RDATA  in  C_DATA_WIDTH  Lite data.
M_AXI_RRESP  in  2  Lite response.
M_AXI_RVALID  in  1  Lite R valid.
M_AXI_RREADY  out  1  Lite R ready.

Behaviour:
- Reset state: FSM in IDLE. Every output is 0, applied immediately on ARESET assertion with no clock edge. S_AXI_ARREADY rises on the first ACLK edge after release.
- Only one burst is outstanding. Only one Lite transaction is outstanding. All outputs are registered.
- FSM states: IDLE, ADDR, WAIT_R, SEND_R.
- IDLE:
  - ARREADY=1.
  - On AR handshake: capture ID, addr, len, size, burst; clear beat_cnt; drop ARREADY.
  - Next state: ADDR. If the burst is illegal, go to SEND_R instead.
- ADDR: M_ARVALID=1 with cur_addr. Hold ARADDR stable until M_ARREADY is seen, then go to WAIT_R.
- WAIT_R:
  - M_RREADY=1.
  - On Lite R handshake: load RDATA and RRESP; set RID; set RLAST=(beat_cnt==len); set RVALID.
  - Next state: SEND_R.
- SEND_R: hold the R outputs stable until S_RREADY.
  - If RLAST: go to IDLE. ARREADY=1 in the following cycle.
  - Otherwise: beat_cnt+1, update cur_addr, go to ADDR.
- Minimum latency: AR handshake at cycle N → M_ARVALID at N+1. Lite R accepted at cycle M → S_RVALID at M+1.
- Address update, with inc = 1<<size:
  - FIXED: unchanged.
  - INCR: cur_addr + inc. Wraps at 2^C_ADDR_WIDTH. No 4 KB check; that is the master's responsibility.
  - WRAP: mask = ((len+1)<<size)-1; next = (cur_addr & ~mask) | ((cur_addr+inc) & mask).
- Illegal bursts:
  - Conditions: burst=11; WRAP with len not in {1,3,7,15}; or size > log2(C_DATA_WIDTH/8).
  - Response: no Lite reads are issued. Every beat returns RRESP=10 (SLVERR) and RDATA=0. beat_cnt and RLAST behave normally.
- RRESP passes through unmodified.
- S_ARVALID while busy: ignored, because ARREADY=0.
- ARESET mid-burst: the burst and any in-flight Lite read are abandoned. The peripheral shares the reset.

Optional Feature:
- Macro: AXI_RD_ERR_ABORT_EN.
- When defined: once any beat returns RRESP[1]=1, the remaining beats of that burst issue no Lite reads. They return the same RRESP with RDATA=0, go straight to SEND_R with one beat per S_RREADY handshake, and keep correct RLAST.
- When undefined: every beat is issued to the Lite slave regardless of earlier errors.

Test Plan:
1. INCR, len=3, size=2, addr=0x1000, ID=1 → Lite reads at 0x1000, 0x1004, 0x1008, 0x100C; RLAST only on beat 4; RID=1 on all beats.
2. WRAP, len=3, size=2, addr=0x2008 → Lite reads at 0x2008, 0x200C, 0x2000, 0x2004.
3. FIXED, len=2, addr=0x3000 → three Lite reads at 0x3000. Reserved burst=11, len=1 → no M_ARVALID; two beats with RRESP=10, RDATA=0, RLAST on beat 2.
4. Back-pressure: M_ARREADY held low 3 cycles → ARADDR stable throughout. S_RREADY held low 5 cycles on beat 1 → RDATA/RRESP/RLAST stable, no beat-2 M_ARVALID until accepted.
5. ARESET pulsed during WAIT_R of beat 2 of a len=3 burst → all outputs 0 in the same cycle. After release: ARREADY=1 next cycle; a new len=0 read completes with RLAST=1.
6. With AXI_RD_ERR_ABORT_EN, Lite returns 10 on beat 1 of len=3 → exactly one Lite read; four beats with RRESP=10. Without the macro → four Lite reads.
